// File: rtl/trap_sequencer_pkg.sv
// Shared encodings for the trap sequencer: trap status codes, FSM states,
// CSR addresses and exception cause codes.
package trap_sequencer_pkg;

  // Trap status from the exception detector.
  typedef enum logic [2:0] {
    TrapNone       = 3'd0,
    TrapEbreak     = 3'd1,
    TrapEcall      = 3'd2,
    TrapMisaligned = 3'd3,
    TrapIllegal    = 3'd4,
    TrapMret       = 3'd5
  } trap_status_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrMepc,
    StWrMcause,
    StWrMtval,
    StRdMtvec,
    StRdMepc,
    StDebug,
    StRedirect
  } trap_state_e;

  localparam logic [11:0] CsrMtvec  = 12'h305;
  localparam logic [11:0] CsrMepc   = 12'h341;
  localparam logic [11:0] CsrMcause = 12'h342;
  localparam logic [11:0] CsrMtval  = 12'h343;

  localparam int unsigned CauseMisaligned = 0;
  localparam int unsigned CauseIllegal    = 2;
  localparam int unsigned CauseBreakpoint = 3;
  localparam int unsigned CauseEcall      = 11;

  // Exception code for a synchronous trap status; 0 for anything else.
  function automatic int unsigned exc_code(logic [2:0] status);
    case (status)
      TrapEcall:      exc_code = CauseEcall;
      TrapIllegal:    exc_code = CauseIllegal;
      TrapEbreak:     exc_code = CauseBreakpoint;
      default:        exc_code = CauseMisaligned;
    endcase
  endfunction

endpackage

// File: rtl/trap_sequencer_irq_priority_encoder.sv
// Lowest-index-wins priority encoder over the masked interrupt lines.
module trap_sequencer_irq_priority_encoder #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [IdxW-1:0]    idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = i[IdxW-1:0];
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Multi-cycle machine-mode trap controller: sequences mepc/mcause/mtval writes
// and the mtvec read on trap entry, mret return, prioritised external
// interrupts with optional vectored dispatch, and an ebreak debug halt.
module trap_sequencer #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_IRQ       = 4,
  parameter int unsigned IRQ_CODE_BASE = 16,
  parameter bit          VECTORED_EN   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         trap_status,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    bad_value,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               debug_resume,
  input  logic [XLEN-1:0]    csr_read_data,
  output logic               trap_busy,
  output logic               trap_done,
  output logic [XLEN-1:0]    trap_target,
  output logic               csr_write_enable,
  output logic [11:0]        csr_trap_address,
  output logic [XLEN-1:0]    csr_trap_write_data,
  output logic               debug_mode
);
  import trap_sequencer_pkg::*;

  localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e       state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   bad_q, bad_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic              in_handler_q, in_handler_d;
  logic              we_q, we_d;
  logic [11:0]       addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              debug_q, debug_d;

  logic              irq_valid;
  logic [IdxW-1:0]   irq_idx;
  logic [XLEN-1:0]   irq_cause;
  logic [XLEN-1:0]   mtvec_base;
  logic              take_event;

  trap_sequencer_irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .IdxW    (IdxW)
  ) u_irq_enc (
    .req_i   (irq & irq_mask),
    .valid_o (irq_valid),
    .idx_o   (irq_idx)
  );

  // Next-state, latch and registered-output computation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    bad_d        = bad_q;
    cause_d      = cause_q;
    in_handler_d = in_handler_q;
    we_d         = 1'b0;
    addr_d       = '0;
    wdata_d      = '0;
    done_d       = 1'b0;
    target_d     = '0;
    debug_d      = 1'b0;
    take_event   = 1'b0;

    irq_cause            = XLEN'(IRQ_CODE_BASE) + XLEN'(irq_idx);
    irq_cause[XLEN-1]    = 1'b1;
    mtvec_base           = {csr_read_data[XLEN-1:2], 2'b00};

    unique case (state_q)
      StIdle: begin
        case (trap_status)
          TrapEbreak: begin
            take_event = 1'b1;
            state_d    = StDebug;
            cause_d    = XLEN'(exc_code(trap_status));
            debug_d    = 1'b1;
          end
          TrapEcall, TrapMisaligned, TrapIllegal: begin
            take_event   = 1'b1;
            state_d      = StWrMepc;
            cause_d      = XLEN'(exc_code(trap_status));
            in_handler_d = 1'b1;
            we_d         = 1'b1;
            addr_d       = CsrMepc;
            wdata_d      = pc;
          end
          TrapMret: begin
            take_event = 1'b1;
            state_d    = StRdMepc;
            cause_d    = '0;
            addr_d     = CsrMepc;
          end
          default: begin
            // Interrupts do not nest: a pending line waits until mret.
            if (irq_valid && !in_handler_q) begin
              take_event   = 1'b1;
              state_d      = StWrMepc;
              cause_d      = irq_cause;
              in_handler_d = 1'b1;
              we_d         = 1'b1;
              addr_d       = CsrMepc;
              wdata_d      = pc;
            end
          end
        endcase
        if (take_event) begin
          pc_d  = pc;
          bad_d = bad_value;
        end
      end
      StWrMepc: begin
        state_d = StWrMcause;
        we_d    = 1'b1;
        addr_d  = CsrMcause;
        wdata_d = cause_q;
      end
      StWrMcause: begin
        state_d = StWrMtval;
        we_d    = 1'b1;
        addr_d  = CsrMtval;
        // Interrupts and ecall carry no trap value.
        wdata_d = (cause_q[XLEN-1] || (cause_q == XLEN'(CauseEcall))) ? '0 : bad_q;
      end
      StWrMtval: begin
        state_d = StRdMtvec;
        addr_d  = CsrMtvec;
      end
      StRdMtvec: begin
        state_d  = StRedirect;
        done_d   = 1'b1;
        target_d = mtvec_base;
        // Vectored offset is 4*cause code; the interrupt flag shifts out the top.
        if (VECTORED_EN && cause_q[XLEN-1] && (csr_read_data[1:0] == 2'b01)) begin
          target_d = mtvec_base + {cause_q[XLEN-3:0], 2'b00};
        end
      end
      StRdMepc: begin
        state_d      = StRedirect;
        done_d       = 1'b1;
        target_d     = {csr_read_data[XLEN-1:2], 2'b00};
        in_handler_d = 1'b0;
      end
      StDebug: begin
        if (debug_resume) begin
          state_d  = StRedirect;
          done_d   = 1'b1;
          target_d = pc_q + XLEN'(4);
        end else begin
          debug_d = 1'b1;
        end
      end
      StRedirect: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    trap_busy = (state_q != StIdle) || take_event;
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      bad_q        <= '0;
      cause_q      <= '0;
      in_handler_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      target_q     <= '0;
      debug_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      bad_q        <= bad_d;
      cause_q      <= cause_d;
      in_handler_q <= in_handler_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      target_q     <= target_d;
      debug_q      <= debug_d;
    end
  end

  assign trap_done           = done_q;
  assign trap_target         = target_q;
  assign csr_write_enable    = we_q;
  assign csr_trap_address    = addr_q;
  assign csr_trap_write_data = wdata_q;
  assign debug_mode          = debug_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios followed by random
// traffic, checked cycle by cycle against a transaction-level schedule model.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  localparam int unsigned Base = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  trap_status;
  logic [31:0] pc, bad_value, csr_read_data;
  logic [3:0]  irq, irq_mask;
  logic        debug_resume;
  logic        trap_busy, trap_done, csr_write_enable, debug_mode;
  logic [31:0] trap_target, csr_trap_write_data;
  logic [11:0] csr_trap_address;

  always #5 clk = ~clk;

  trap_sequencer #(
    .XLEN          (32),
    .NUM_IRQ       (4),
    .IRQ_CODE_BASE (Base),
    .VECTORED_EN   (1'b1)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .trap_status         (trap_status),
    .pc                  (pc),
    .bad_value           (bad_value),
    .irq                 (irq),
    .irq_mask            (irq_mask),
    .debug_resume        (debug_resume),
    .csr_read_data       (csr_read_data),
    .trap_busy           (trap_busy),
    .trap_done           (trap_done),
    .trap_target         (trap_target),
    .csr_write_enable    (csr_write_enable),
    .csr_trap_address    (csr_trap_address),
    .csr_trap_write_data (csr_trap_write_data),
    .debug_mode          (debug_mode)
  );

  // Small CSR file the DUT talks to.
  logic [31:0] csr_mtvec = '0, csr_mepc = '0, csr_mcause = '0, csr_mtval = '0;
  always_comb begin
    csr_read_data = '0;
    case (csr_trap_address)
      12'h305: csr_read_data = csr_mtvec;
      12'h341: csr_read_data = csr_mepc;
      12'h342: csr_read_data = csr_mcause;
      12'h343: csr_read_data = csr_mtval;
      default: csr_read_data = '0;
    endcase
  end

  // Expected outputs for one cycle.
  typedef struct {
    bit          busy;
    bit          done;
    bit          we;
    bit          dbg;
    bit          wd_dc;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] target;
  } exp_t;

  exp_t        sched[$];
  bit          m_debug = 1'b0, m_inh = 1'b0;
  logic [31:0] m_dpc = '0, m_mepc = '0, last_tgt = '0;
  int          n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t mk(bit busy, bit done, bit we, bit dbg, bit wd_dc,
                              logic [11:0] addr, logic [31:0] wdata, logic [31:0] target);
    exp_t e;
    e.busy = busy; e.done = done; e.we = we; e.dbg = dbg; e.wd_dc = wd_dc;
    e.addr = addr; e.wdata = wdata; e.target = target;
    return e;
  endfunction

  // Trap entry: four bus cycles then the redirect, all planned up front.
  task automatic schedule_trap(input logic [31:0] cause, input logic [31:0] mtval);
    logic [31:0] tgt;
    m_mepc = pc;
    m_inh  = 1'b1;
    tgt    = csr_mtvec & 32'hFFFF_FFFC;
    if (cause[31] && csr_mtvec[1:0] == 2'b01) tgt = tgt + 4 * (cause & 32'h7FFF_FFFF);
    sched.push_back(mk(1, 0, 1, 0, 0, 12'h341, pc, 0));
    sched.push_back(mk(1, 0, 1, 0, 0, 12'h342, cause, 0));
    sched.push_back(mk(1, 0, 1, 0, 0, 12'h343, mtval, 0));
    sched.push_back(mk(1, 0, 0, 0, 1, 12'h305, 0, 0));
    sched.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, tgt));
  endtask

  function automatic bit model_idle();
    return (sched.size() == 0) && !m_debug;
  endfunction

  // One cycle: entered at a negedge with inputs driven, leaves at the next negedge.
  task automatic step();
    exp_t        e;
    logic [3:0]  pend;
    #1;
    e    = mk(0, 0, 0, 0, 0, 12'h000, 0, 0);
    pend = irq & irq_mask;
    if (sched.size() > 0) begin
      e = sched.pop_front();
    end else if (m_debug) begin
      e = mk(1, 0, 0, 1, 0, 12'h000, 0, 0);
      if (debug_resume) begin
        sched.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, m_dpc + 4));
        m_debug = 1'b0;
      end
    end else begin
      case (trap_status)
        TrapEbreak:     begin e.busy = 1; m_debug = 1'b1; m_dpc = pc; end
        TrapEcall:      begin e.busy = 1; schedule_trap(32'd11, 32'd0); end
        TrapMisaligned: begin e.busy = 1; schedule_trap(32'd0, bad_value); end
        TrapIllegal:    begin e.busy = 1; schedule_trap(32'd2, bad_value); end
        TrapMret: begin
          e.busy = 1;
          sched.push_back(mk(1, 0, 0, 0, 1, 12'h341, 0, 0));
          sched.push_back(mk(1, 1, 0, 0, 0, 12'h000, 0, m_mepc & 32'hFFFF_FFFC));
          m_inh = 1'b0;
        end
        default: begin
          if (pend != 0 && !m_inh) begin
            int lo = 0;
            while (!pend[lo]) lo++;
            e.busy = 1;
            schedule_trap(32'h8000_0000 | (Base + lo), 32'd0);
          end
        end
      endcase
    end
    check_eq("busy", trap_busy, e.busy);
    check_eq("done", trap_done, e.done);
    if (e.done) check_eq("target", trap_target, e.target);
    check_eq("csr_we", csr_write_enable, e.we);
    check_eq("csr_addr", csr_trap_address, e.addr);
    if (!e.wd_dc) check_eq("csr_wdata", csr_trap_write_data, e.wdata);
    check_eq("debug_mode", debug_mode, e.dbg);
    if (trap_done === 1'b1) last_tgt = trap_target;
    if (csr_write_enable === 1'b1) begin
      case (csr_trap_address)
        12'h341: csr_mepc   = csr_trap_write_data;
        12'h342: csr_mcause = csr_trap_write_data;
        12'h343: csr_mtval  = csr_trap_write_data;
        default: ;
      endcase
    end
    if (reset) begin
      sched.delete();
      m_debug = 1'b0;
      m_inh   = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_mret();
    trap_status = TrapMret;
    step();
    trap_status = TrapNone;
    run(2);
  endtask

  initial begin
    reset = 1'b1; trap_status = TrapNone; pc = '0; bad_value = '0;
    irq = '0; irq_mask = '0; debug_resume = 1'b0;
    repeat (2) @(negedge clk);
    step();
    reset = 1'b0;
    run(1);

    // ILLEGAL with direct mtvec.
    csr_mtvec = 32'h0000_2000;
    trap_status = TrapIllegal; pc = 32'h100; bad_value = 32'hFFFF_FFFF;
    step();
    trap_status = TrapNone;
    run(6);
    check_eq("ill_mepc", csr_mepc, 32'h100);
    check_eq("ill_mcause", csr_mcause, 32'd2);
    check_eq("ill_mtval", csr_mtval, 32'hFFFF_FFFF);
    check_eq("ill_target", last_tgt, 32'h2000);
    do_mret();

    // Vectored irq[2]; irq[1] during the handler must wait for mret.
    csr_mtvec = 32'h0000_2001;
    irq = 4'b0100; irq_mask = 4'b0100; pc = 32'h300;
    step();
    irq = 4'b0010; irq_mask = 4'b0110;
    run(5);
    check_eq("irq2_mcause", csr_mcause, 32'h8000_0012);
    check_eq("irq2_target", last_tgt, 32'h2048);
    run(8);
    csr_mepc = 32'h0000_0107; m_mepc = 32'h0000_0107;
    do_mret();
    check_eq("mret_target", last_tgt, 32'h104);
    run(6);
    check_eq("irq1_mcause", csr_mcause, 32'h8000_0011);
    check_eq("irq1_target", last_tgt, 32'h2044);
    irq = '0;
    do_mret();

    // EBREAK halt and resume; stray resume in idle is ignored.
    trap_status = TrapEbreak; pc = 32'h200;
    step();
    trap_status = TrapNone;
    run(10);
    debug_resume = 1'b1;
    step();
    debug_resume = 1'b0;
    step();
    check_eq("dbg_target", last_tgt, 32'h204);
    debug_resume = 1'b1;
    step();
    debug_resume = 1'b0;
    run(2);

    // ECALL and irq[0] together: exception wins, irq stays pending.
    trap_status = TrapEcall; irq = 4'b0001; irq_mask = 4'b0001; bad_value = 32'hDEAD_BEEF;
    pc = 32'h500;
    step();
    trap_status = TrapNone;
    run(5);
    check_eq("ecall_mcause", csr_mcause, 32'd11);
    check_eq("ecall_mtval", csr_mtval, 32'd0);
    do_mret();
    run(6);
    check_eq("irq0_mcause", csr_mcause, 32'h8000_0010);
    irq = '0;

    // Reset during WR_MCAUSE, then a clean ECALL.
    trap_status = TrapEcall; pc = 32'h600;
    step();
    trap_status = TrapNone;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    trap_status = TrapEcall; pc = 32'h400;
    step();
    trap_status = TrapNone;
    run(5);
    check_eq("rst_mepc", csr_mepc, 32'h400);
    check_eq("rst_mcause", csr_mcause, 32'd11);
    check_eq("rst_target", last_tgt, 32'h2000);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      int r;
      if (model_idle()) begin
        if ($urandom_range(0, 9) == 0) csr_mtvec = $urandom;
        if ($urandom_range(0, 9) == 0) begin
          csr_mepc = $urandom;
          m_mepc   = csr_mepc;
        end
      end
      r = $urandom_range(0, 99);
      if (r < 70)      trap_status = TrapNone;
      else if (r < 74) trap_status = TrapEbreak;
      else if (r < 79) trap_status = TrapEcall;
      else if (r < 83) trap_status = TrapMisaligned;
      else if (r < 87) trap_status = TrapIllegal;
      else if (r < 94) trap_status = TrapMret;
      else             trap_status = TrapNone;
      irq          = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      irq_mask     = 4'($urandom);
      debug_resume = ($urandom_range(0, 7) == 0);
      pc           = $urandom;
      bad_value    = $urandom;
      reset        = ($urandom_range(0, 199) == 0);
      if (reset) begin
        trap_status = TrapNone;
        irq         = '0;
      end
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
